// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order reorder buffer: allocate, capture writebacks, forward operands, retire.
// Optional ROB_COMMIT_LOG_EN adds a commit log print and a retired-instruction counter.
module reorder_buffer #(
    parameter int ROB_WIDTH_BIT = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush,
    input  logic                     issue_valid,
    input  logic                     issue_has_rd,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_done,
    input  logic [31:0]              issue_value,
    output logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
    output logic                     full,
    input  logic                     rs_ready,
    input  logic [ROB_WIDTH_BIT-1:0] rs_rob_id,
    input  logic [31:0]              rs_value,
    input  logic                     lsb_ready,
    input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
    input  logic [31:0]              lsb_value,
    input  logic [ROB_WIDTH_BIT-1:0] q1_id,
    output logic                     q1_ready,
    output logic [31:0]              q1_value,
    input  logic [ROB_WIDTH_BIT-1:0] q2_id,
    output logic                     q2_ready,
    output logic [31:0]              q2_value,
    output logic                     commit_valid,
    output logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    output logic                     commit_has_rd,
    output logic [4:0]               commit_rd,
    output logic [31:0]              commit_value
);

    localparam int DEPTH = 1 << ROB_WIDTH_BIT;
    localparam logic [ROB_WIDTH_BIT:0] FULL_COUNT = {1'b1, {ROB_WIDTH_BIT{1'b0}}};

    logic [DEPTH-1:0]         busy_q;
    logic [DEPTH-1:0]         done_q;
    logic [DEPTH-1:0]         has_rd_q;
    logic [4:0]               rd_q    [DEPTH];
    logic [31:0]              value_q [DEPTH];
    logic [ROB_WIDTH_BIT-1:0] head_q;
    logic [ROB_WIDTH_BIT-1:0] tail_q;
    logic [ROB_WIDTH_BIT:0]   count_q;

    logic issue_accept;
    logic commit_fire;
    logic rs_wb;
    logic lsb_wb;

    assign full         = (count_q == FULL_COUNT);
    assign issue_rob_id = tail_q;

    // A slot freed by this cycle's commit is not visible to issue until next cycle.
    assign issue_accept = issue_valid && !full;
    assign commit_fire  = (count_q != '0) && busy_q[head_q] && done_q[head_q];
    assign rs_wb        = rs_ready && busy_q[rs_rob_id];
    assign lsb_wb       = lsb_ready && busy_q[lsb_rob_id];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q        <= '0;
            done_q        <= '0;
            has_rd_q      <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            commit_valid  <= 1'b0;
            commit_rob_id <= '0;
            commit_has_rd <= 1'b0;
            commit_rd     <= '0;
            commit_value  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]    <= '0;
                value_q[i] <= '0;
            end
        end else if (!rdy_in) begin
            commit_valid <= 1'b0;
        end else if (flush) begin
            busy_q       <= '0;
            done_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            commit_valid <= 1'b0;
        end else begin
            commit_valid <= 1'b0;

            // LSB assignment comes last so it wins if both buses name one id.
            if (rs_wb) begin
                done_q[rs_rob_id]  <= 1'b1;
                value_q[rs_rob_id] <= rs_value;
            end
            if (lsb_wb) begin
                done_q[lsb_rob_id]  <= 1'b1;
                value_q[lsb_rob_id] <= lsb_value;
            end

            if (issue_accept) begin
                busy_q[tail_q]   <= 1'b1;
                done_q[tail_q]   <= issue_done;
                has_rd_q[tail_q] <= issue_has_rd;
                rd_q[tail_q]     <= issue_rd;
                value_q[tail_q]  <= issue_value;
                tail_q           <= tail_q + 1'b1;
            end

            if (commit_fire) begin
                busy_q[head_q] <= 1'b0;
                done_q[head_q] <= 1'b0;
                commit_valid   <= 1'b1;
                commit_rob_id  <= head_q;
                commit_has_rd  <= has_rd_q[head_q];
                commit_rd      <= rd_q[head_q];
                commit_value   <= value_q[head_q];
                head_q         <= head_q + 1'b1;
            end

            case ({issue_accept, commit_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Stored result beats the live buses; only busy entries ever answer.
    always_comb begin
        q1_ready = 1'b0;
        q1_value = '0;
        if (busy_q[q1_id]) begin
            if (done_q[q1_id]) begin
                q1_ready = 1'b1;
                q1_value = value_q[q1_id];
            end else if (rs_ready && (rs_rob_id == q1_id)) begin
                q1_ready = 1'b1;
                q1_value = rs_value;
            end else if (lsb_ready && (lsb_rob_id == q1_id)) begin
                q1_ready = 1'b1;
                q1_value = lsb_value;
            end
        end
    end

    always_comb begin
        q2_ready = 1'b0;
        q2_value = '0;
        if (busy_q[q2_id]) begin
            if (done_q[q2_id]) begin
                q2_ready = 1'b1;
                q2_value = value_q[q2_id];
            end else if (rs_ready && (rs_rob_id == q2_id)) begin
                q2_ready = 1'b1;
                q2_value = rs_value;
            end else if (lsb_ready && (lsb_rob_id == q2_id)) begin
                q2_ready = 1'b1;
                q2_value = lsb_value;
            end
        end
    end

`ifdef ROB_COMMIT_LOG_EN
    logic [31:0] retired_count;

    // Survives flush: counts every instruction ever retired since reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            retired_count <= '0;
        end else if (rdy_in && !flush && commit_fire) begin
            retired_count <= retired_count + 1'b1;
        end
    end

    always @(posedge clk_in) begin
        if (rst_in && rdy_in && !flush && commit_fire) begin
            $display("[ROB] commit id=%0d rd=%0d val=%h", head_q, rd_q[head_q], value_q[head_q]);
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        issue_valid;
    logic        issue_has_rd;
    logic [4:0]  issue_rd;
    logic        issue_done;
    logic [31:0] issue_value;
    logic [2:0]  issue_rob_id;
    logic        full;
    logic        rs_ready;
    logic [2:0]  rs_rob_id;
    logic [31:0] rs_value;
    logic        lsb_ready;
    logic [2:0]  lsb_rob_id;
    logic [31:0] lsb_value;
    logic [2:0]  q1_id;
    logic        q1_ready;
    logic [31:0] q1_value;
    logic [2:0]  q2_id;
    logic        q2_ready;
    logic [31:0] q2_value;
    logic        commit_valid;
    logic [2:0]  commit_rob_id;
    logic        commit_has_rd;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;

    int compared   = 0;
    int mismatched = 0;

    reorder_buffer #(.ROB_WIDTH_BIT(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .issue_valid(issue_valid), .issue_has_rd(issue_has_rd), .issue_rd(issue_rd),
        .issue_done(issue_done), .issue_value(issue_value),
        .issue_rob_id(issue_rob_id), .full(full),
        .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .q1_id(q1_id), .q1_ready(q1_ready), .q1_value(q1_value),
        .q2_id(q2_id), .q2_ready(q2_ready), .q2_value(q2_value),
        .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
        .commit_has_rd(commit_has_rd), .commit_rd(commit_rd), .commit_value(commit_value)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic idle_inputs();
        rdy_in       = 1'b1;
        flush        = 1'b0;
        issue_valid  = 1'b0;
        issue_has_rd = 1'b0;
        issue_rd     = '0;
        issue_done   = 1'b0;
        issue_value  = '0;
        rs_ready     = 1'b0;
        rs_rob_id    = '0;
        rs_value     = '0;
        lsb_ready    = 1'b0;
        lsb_rob_id   = '0;
        lsb_value    = '0;
        q1_id        = '0;
        q2_id        = '0;
    endtask

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_in = 1'b0;
        #2;
        rst_in = 1'b1;
    endtask

    task automatic set_issue(input logic v, input logic [4:0] rd, input logic dn, input logic [31:0] val);
        issue_valid  = v;
        issue_has_rd = v;
        issue_rd     = rd;
        issue_done   = dn;
        issue_value  = val;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_in = 1'b0;
        #2;
        compared++; if (full !== 1'b0) begin mismatched++; $display("FAIL reset_full got=%0h exp=0", full); end
        compared++; if (issue_rob_id !== 3'd0) begin mismatched++; $display("FAIL reset_tail got=%0d exp=0", issue_rob_id); end
        compared++; if (commit_valid !== 1'b0) begin mismatched++; $display("FAIL reset_commit_valid got=%0h exp=0", commit_valid); end
        compared++; if ({commit_rob_id, commit_has_rd, commit_rd, commit_value} !== '0) begin
            mismatched++; $display("FAIL reset_commit_fields got=%0h/%0h/%0h/%0h exp=0", commit_rob_id, commit_has_rd, commit_rd, commit_value);
        end
        rst_in = 1'b1;
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            set_issue(1'b1, 5'(i + 1), 1'b0, 32'h0);
            compared++; if (issue_rob_id !== 3'(i)) begin mismatched++; $display("FAIL fill_id[%0d] got=%0d exp=%0d", i, issue_rob_id, i); end
            cycle();
        end
        compared++; if (full !== 1'b1) begin mismatched++; $display("FAIL fill_full got=%0h exp=1", full); end
        cycle();
        compared++; if (issue_rob_id !== 3'd0) begin mismatched++; $display("FAIL fill_ninth_tail got=%0d exp=0", issue_rob_id); end
        compared++; if (full !== 1'b1) begin mismatched++; $display("FAIL fill_ninth_full got=%0h exp=1", full); end
        compared++; if (commit_valid !== 1'b0) begin mismatched++; $display("FAIL fill_no_commit got=%0h exp=0", commit_valid); end
        set_issue(1'b0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic test_single_commit();
        apply_reset();
        set_issue(1'b1, 5'd5, 1'b0, 32'h0);
        cycle();
        set_issue(1'b0, 5'd0, 1'b0, 32'h0);
        rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'h1234;
        cycle();
        rs_ready = 1'b0;
        compared++; if (commit_valid !== 1'b0) begin mismatched++; $display("FAIL single_early got=%0h exp=0", commit_valid); end
        cycle();
        compared++; if (commit_valid !== 1'b1) begin mismatched++; $display("FAIL single_valid got=%0h exp=1", commit_valid); end
        compared++; if (commit_rd !== 5'd5) begin mismatched++; $display("FAIL single_rd got=%0d exp=5", commit_rd); end
        compared++; if (commit_value !== 32'h1234) begin mismatched++; $display("FAIL single_value got=%h exp=00001234", commit_value); end
        compared++; if ({commit_rob_id, commit_has_rd} !== {3'd0, 1'b1}) begin mismatched++; $display("FAIL single_id_hasrd got=%0d/%0h exp=0/1", commit_rob_id, commit_has_rd); end
        cycle();
        compared++; if (commit_valid !== 1'b0) begin mismatched++; $display("FAIL single_pulse got=%0h exp=0", commit_valid); end
        compared++; if ({full, issue_rob_id} !== {1'b0, 3'd1}) begin mismatched++; $display("FAIL single_ptr got=%0h/%0d exp=0/1", full, issue_rob_id); end
    endtask

    task automatic test_in_order();
        apply_reset();
        set_issue(1'b1, 5'd1, 1'b0, 32'h0);
        cycle();
        set_issue(1'b1, 5'd2, 1'b0, 32'h0);
        cycle();
        set_issue(1'b0, 5'd0, 1'b0, 32'h0);
        lsb_ready = 1'b1; lsb_rob_id = 3'd1; lsb_value = 32'hAA;
        cycle();
        lsb_ready = 1'b0;
        compared++; if (commit_valid !== 1'b0) begin mismatched++; $display("FAIL order_hold got=%0h exp=0", commit_valid); end
        rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'h55;
        cycle();
        rs_ready = 1'b0;
        compared++; if (commit_valid !== 1'b0) begin mismatched++; $display("FAIL order_latency got=%0h exp=0", commit_valid); end
        cycle();
        compared++; if ({commit_valid, commit_rob_id, commit_value} !== {1'b1, 3'd0, 32'h55}) begin
            mismatched++; $display("FAIL order_first got=%0h/%0d/%h exp=1/0/00000055", commit_valid, commit_rob_id, commit_value);
        end
        cycle();
        compared++; if ({commit_valid, commit_rob_id, commit_rd, commit_value} !== {1'b1, 3'd1, 5'd2, 32'hAA}) begin
            mismatched++; $display("FAIL order_second got=%0h/%0d/%0d/%h exp=1/1/2/000000aa", commit_valid, commit_rob_id, commit_rd, commit_value);
        end
        cycle();
        compared++; if (commit_valid !== 1'b0) begin mismatched++; $display("FAIL order_end got=%0h exp=0", commit_valid); end
    endtask

    task automatic test_query();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_issue(1'b1, 5'(i + 3), 1'b0, 32'h0);
            cycle();
        end
        set_issue(1'b0, 5'd0, 1'b0, 32'h0);
        q1_id = 3'd2; q2_id = 3'd1;
        rs_ready = 1'b1; rs_rob_id = 3'd2; rs_value = 32'h77;
        #1;
        compared++; if ({q1_ready, q1_value} !== {1'b1, 32'h77}) begin mismatched++; $display("FAIL query_bus got=%0h/%h exp=1/00000077", q1_ready, q1_value); end
        compared++; if ({q2_ready, q2_value} !== {1'b0, 32'h0}) begin mismatched++; $display("FAIL query_pending got=%0h/%h exp=0/0", q2_ready, q2_value); end
        cycle();
        rs_ready = 1'b1; rs_rob_id = 3'd2; rs_value = 32'h11;
        lsb_ready = 1'b1; lsb_rob_id = 3'd1; lsb_value = 32'h99;
        #1;
        compared++; if ({q1_ready, q1_value} !== {1'b1, 32'h77}) begin mismatched++; $display("FAIL query_stored got=%0h/%h exp=1/00000077", q1_ready, q1_value); end
        compared++; if ({q2_ready, q2_value} !== {1'b1, 32'h99}) begin mismatched++; $display("FAIL query_lsb got=%0h/%h exp=1/00000099", q2_ready, q2_value); end
        rs_ready = 1'b0; lsb_ready = 1'b0;
        q2_id = 3'd5;
        #1;
        compared++; if (q2_ready !== 1'b0) begin mismatched++; $display("FAIL query_not_busy got=%0h exp=0", q2_ready); end
        q1_id = 3'd0; q2_id = 3'd0;
    endtask

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            set_issue(1'b1, 5'(i + 8), 1'b0, 32'h0);
            cycle();
        end
        set_issue(1'b0, 5'd0, 1'b0, 32'h0);
        rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'hC0;
        cycle();
        rs_ready = 1'b0;
        set_issue(1'b1, 5'd9, 1'b0, 32'h0);
        compared++; if (full !== 1'b1) begin mismatched++; $display("FAIL wrap_full_before got=%0h exp=1", full); end
        cycle();
        compared++; if ({commit_valid, commit_rob_id, commit_value} !== {1'b1, 3'd0, 32'hC0}) begin
            mismatched++; $display("FAIL wrap_commit got=%0h/%0d/%h exp=1/0/000000c0", commit_valid, commit_rob_id, commit_value);
        end
        compared++; if ({full, issue_rob_id} !== {1'b0, 3'd0}) begin mismatched++; $display("FAIL wrap_issue_ignored got=%0h/%0d exp=0/0", full, issue_rob_id); end
        cycle();
        set_issue(1'b0, 5'd0, 1'b0, 32'h0);
        compared++; if ({full, issue_rob_id} !== {1'b1, 3'd1}) begin mismatched++; $display("FAIL wrap_issue_accepted got=%0h/%0d exp=1/1", full, issue_rob_id); end
        compared++; if (commit_valid !== 1'b0) begin mismatched++; $display("FAIL wrap_no_commit got=%0h exp=0", commit_valid); end
    endtask

    task automatic test_pause();
        apply_reset();
        rdy_in = 1'b0;
        set_issue(1'b1, 5'd7, 1'b1, 32'hBEEF);
        cycle();
        compared++; if (issue_rob_id !== 3'd0) begin mismatched++; $display("FAIL pause_issue_held got=%0d exp=0", issue_rob_id); end
        rdy_in = 1'b1;
        cycle();
        set_issue(1'b0, 5'd0, 1'b0, 32'h0);
        compared++; if (issue_rob_id !== 3'd1) begin mismatched++; $display("FAIL pause_issue_taken got=%0d exp=1", issue_rob_id); end
        rdy_in = 1'b0;
        cycle();
        compared++; if (commit_valid !== 1'b0) begin mismatched++; $display("FAIL pause_commit_held got=%0h exp=0", commit_valid); end
        rdy_in = 1'b1;
        cycle();
        compared++; if ({commit_valid, commit_rd, commit_value} !== {1'b1, 5'd7, 32'hBEEF}) begin
            mismatched++; $display("FAIL pause_commit got=%0h/%0d/%h exp=1/7/0000beef", commit_valid, commit_rd, commit_value);
        end
        cycle();
        compared++; if (commit_valid !== 1'b0) begin mismatched++; $display("FAIL pause_single got=%0h exp=0", commit_valid); end
    endtask

    task automatic test_flush();
        apply_reset();
        set_issue(1'b1, 5'd1, 1'b0, 32'h0);
        cycle();
        set_issue(1'b1, 5'd2, 1'b1, 32'h22);
        cycle();
        set_issue(1'b1, 5'd3, 1'b0, 32'h0);
        cycle();
        flush = 1'b1;
        set_issue(1'b1, 5'd4, 1'b1, 32'h44);
        rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'h10;
        cycle();
        flush = 1'b0;
        set_issue(1'b0, 5'd0, 1'b0, 32'h0);
        rs_ready = 1'b0;
        compared++; if ({full, issue_rob_id, commit_valid} !== {1'b0, 3'd0, 1'b0}) begin
            mismatched++; $display("FAIL flush_state got=%0h/%0d/%0h exp=0/0/0", full, issue_rob_id, commit_valid);
        end
        q1_id = 3'd1;
        #1;
        compared++; if (q1_ready !== 1'b0) begin mismatched++; $display("FAIL flush_query got=%0h exp=0", q1_ready); end
        cycle();
        compared++; if (commit_valid !== 1'b0) begin mismatched++; $display("FAIL flush_no_commit got=%0h exp=0", commit_valid); end
        set_issue(1'b1, 5'd6, 1'b1, 32'hEE);
        cycle();
        set_issue(1'b0, 5'd0, 1'b0, 32'h0);
        cycle();
        compared++; if ({commit_valid, commit_rob_id, commit_value} !== {1'b1, 3'd0, 32'hEE}) begin
            mismatched++; $display("FAIL flush_after_commit got=%0h/%0d/%h exp=1/0/000000ee", commit_valid, commit_rob_id, commit_value);
        end
        rst_in = 1'b0;
        #1;
        compared++; if ({commit_valid, commit_rd, commit_value, issue_rob_id} !== '0) begin
            mismatched++; $display("FAIL async_reset got=%0h/%0d/%h/%0d exp=0/0/0/0", commit_valid, commit_rd, commit_value, issue_rob_id);
        end
        rst_in = 1'b1;
        q1_id = 3'd0;
    endtask

    initial begin
        rst_in = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        cycle();
        test_fill();
        test_single_commit();
        test_in_order();
        test_query();
        test_full_wrap();
        test_pause();
        test_flush();
        cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
